register_file_2r1w: RTL and testbench
=====================================

REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per entry (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of entries (>=2).
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning 1 = entry 0 always reads 0 and ignores writes.
REQ-004 The block SHALL define localparam AW = clog2(DEPTH), minimum 1, as the address width.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 The block SHALL have port Reset_N, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port WriteEn, input, 1 bit: write strobe.
REQ-008 The block SHALL have port WriteAddr, input, AW bits: write entry index.
REQ-009 The block SHALL have port WriteData, input, WIDTH bits: write data.
REQ-010 The block SHALL have ports ReadEnA and ReadEnB, input, 1 bit each: read strobes for ports A and B.
REQ-011 The block SHALL have ports ReadAddrA and ReadAddrB, input, AW bits each: read indices.
REQ-012 The block SHALL have ports OutA and OutB, output, WIDTH bits each: registered read data.
REQ-013 The block SHALL have port Clear, input, 1 bit: request to zero all entries.
REQ-014 The block SHALL have port Busy, output, 1 bit: clear sequence in progress.
REQ-015 The block SHALL have port ClearDone, output, 1 bit: one-cycle pulse marking clear completion.

Function
REQ-016 Writes SHALL commit on the rising Clk edge when WriteEn=1, Busy=0 and WriteAddr<DEPTH; all other write attempts SHALL be silently dropped.
REQ-017 With ZERO_REG=1, writes to entry 0 SHALL be dropped and reads of entry 0 SHALL return 0.
REQ-018 Read latency SHALL be 1 cycle: when ReadEnX=1 at an edge, OutX SHALL load entry[ReadAddrX]; when ReadEnX=0, OutX SHALL hold its value.
REQ-019 A read of an address >= DEPTH SHALL return 0.
REQ-020 Bypass: when a committing write (REQ-016) targets the same address a port reads in the same cycle, that port SHALL return WriteData, not the old contents.
REQ-021 Ports A and B SHALL be fully independent; equal addresses on both ports SHALL return identical data.
REQ-022 The clear FSM SHALL have states IDLE, CLEAR and DONE.
REQ-023 IDLE SHALL go to CLEAR on Clear=1, loading the clear pointer with 0.
REQ-024 In CLEAR, entry[pointer] SHALL be zeroed each cycle and the pointer incremented; when pointer=DEPTH-1 the FSM SHALL go to DONE.
REQ-025 DONE SHALL go to IDLE unconditionally after one cycle.
REQ-026 Busy SHALL be 1 exactly while in CLEAR (DEPTH cycles); ClearDone SHALL be 1 exactly while in DONE.
REQ-027 Clear asserted while in CLEAR or DONE SHALL be ignored; Clear held high SHALL restart the sequence from IDLE on the cycle after DONE.
REQ-028 Reads during CLEAR SHALL be serviced from current array contents (already-cleared entries read 0); no bypass from clear writes.
REQ-029 A Clear and a WriteEn sampled in the same IDLE cycle SHALL both take effect: the write commits, then CLEAR zeroes it.

Reset
REQ-030 Reset_N=0 SHALL immediately, without a clock edge, set all entries, OutA and OutB to 0, Busy=0, ClearDone=0, FSM=IDLE and pointer=0.
REQ-031 Reset_N=0 during CLEAR SHALL abort the sequence; no ClearDone pulse SHALL follow.
REQ-032 Operation SHALL resume on the first rising Clk edge after Reset_N deasserts.

Verification (defaults WIDTH=8, DEPTH=8, ZERO_REG=1)
REQ-033 Bench SHALL cover: write 0xA5 to entry 3, then ReadEnA=1 with ReadAddrA=3 -> OutA=0xA5 one cycle later; OutB unchanged.
REQ-034 Bench SHALL cover: in one cycle, write 0x3C to entry 5 while ReadAddrA=ReadAddrB=5 with both read strobes high -> OutA=OutB=0x3C (bypass).
REQ-035 Bench SHALL cover: write 0xFF to entry 0, then read entry 0 -> OutA=0x00.
REQ-036 Bench SHALL cover: fill entries 1..7 with nonzero data, pulse Clear -> Busy=1 for exactly 8 cycles, ClearDone=1 for 1 cycle, WriteEn during Busy dropped, all entries then read 0x00.
REQ-037 Bench SHALL cover: pulse Clear, drive Reset_N low 3 cycles later -> all outputs 0 immediately, no ClearDone pulse, then a write/read of 0x5A on entry 2 works.
REQ-038 Bench SHALL cover: ReadEnA=0 across a write to the addressed entry -> OutA holds its previous value.

Source files
------------

// File: rtl/register_file_2r1w.sv
// Two-read/one-write register file with registered read ports, write-to-read
// bypass, optional hard-wired zero entry and a sequential clear engine.
module register_file_2r1w #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                                            Clk,
  input  logic                                            Reset_N,
  input  logic                                            WriteEn,
  input  logic [(($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH))-1:0] WriteAddr,
  input  logic [WIDTH-1:0]                                WriteData,
  input  logic                                            ReadEnA,
  input  logic                                            ReadEnB,
  input  logic [(($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH))-1:0] ReadAddrA,
  input  logic [(($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH))-1:0] ReadAddrB,
  output logic [WIDTH-1:0]                                OutA,
  output logic [WIDTH-1:0]                                OutB,
  input  logic                                            Clear,
  output logic                                            Busy,
  output logic                                            ClearDone
);

  localparam int unsigned AW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_ok_c;
  logic [WIDTH-1:0] rd_a_c;
  logic [WIDTH-1:0] rd_b_c;

  // A write commits only outside the clear sweep, in range, and not to a hard-wired zero entry
  assign wr_ok_c = WriteEn && !Busy && (32'(WriteAddr) < DEPTH)
                   && !((ZERO_REG != 0) && (WriteAddr == '0));

  always_comb begin
    rd_a_c = '0;
    if ((32'(ReadAddrA) < DEPTH) && !((ZERO_REG != 0) && (ReadAddrA == '0))) begin
      if (wr_ok_c && (WriteAddr == ReadAddrA)) begin
        rd_a_c = WriteData;
      end else begin
        rd_a_c = mem[ReadAddrA];
      end
    end
  end

  always_comb begin
    rd_b_c = '0;
    if ((32'(ReadAddrB) < DEPTH) && !((ZERO_REG != 0) && (ReadAddrB == '0))) begin
      if (wr_ok_c && (WriteAddr == ReadAddrB)) begin
        rd_b_c = WriteData;
      end else begin
        rd_b_c = mem[ReadAddrB];
      end
    end
  end

  // Storage: the clear sweep and host writes are mutually exclusive via Busy
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_ok_c) begin
      mem[WriteAddr] <= WriteData;
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      OutA <= '0;
      OutB <= '0;
    end else begin
      if (ReadEnA) OutA <= rd_a_c;
      if (ReadEnB) OutB <= rd_b_c;
    end
  end

  // Clear sequencer: one entry per cycle, then a single-cycle completion pulse
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state     <= IDLE;
      ptr       <= '0;
      Busy      <= 1'b0;
      ClearDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Clear) begin
            state <= CLEAR;
            ptr   <= '0;
            Busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == AW'(DEPTH - 1)) begin
            state     <= DONE;
            Busy      <= 1'b0;
            ClearDone <= 1'b1;
          end else begin
            ptr <= ptr + AW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          ClearDone <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          Busy      <= 1'b0;
          ClearDone <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the register file.
module tb_register_file_2r1w;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic             Clk;
  logic             Reset_N;
  logic             WriteEn;
  logic [AW-1:0]    WriteAddr;
  logic [WIDTH-1:0] WriteData;
  logic             ReadEnA;
  logic             ReadEnB;
  logic [AW-1:0]    ReadAddrA;
  logic [AW-1:0]    ReadAddrB;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;
  logic             Clear;
  logic             Busy;
  logic             ClearDone;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_a;
  logic [WIDTH-1:0] exp_b;
  bit               exp_busy;
  bit               exp_done;
  int               clr_idx;

  register_file_2r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .WriteEn(WriteEn), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .ReadEnA(ReadEnA), .ReadEnB(ReadEnB),
    .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
    .OutA(OutA), .OutB(OutB),
    .Clear(Clear), .Busy(Busy), .ClearDone(ClearDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    exp_a = '0; exp_b = '0; exp_busy = 0; exp_done = 0; clr_idx = 0;
  endtask

  task automatic idle_inputs();
    WriteEn = 0; WriteAddr = '0; WriteData = '0;
    ReadEnA = 0; ReadEnB = 0; ReadAddrA = '0; ReadAddrB = '0; Clear = 0;
  endtask

  function automatic logic [WIDTH-1:0] ref_read(input int addr, input bit commit);
    if (addr >= int'(DEPTH) || addr == 0) return '0;
    if (commit && addr == int'(WriteAddr)) return WriteData;
    return ref_mem[addr];
  endfunction

  // Advance the model by one clock using the currently driven inputs, then step the DUT
  task automatic tick();
    bit commit;
    commit = WriteEn && !exp_busy && (int'(WriteAddr) < int'(DEPTH)) && (WriteAddr != '0);
    if (ReadEnA) exp_a = ref_read(int'(ReadAddrA), commit);
    if (ReadEnB) exp_b = ref_read(int'(ReadAddrB), commit);
    if (exp_busy) begin
      ref_mem[clr_idx] = '0;
      clr_idx++;
      if (clr_idx == int'(DEPTH)) begin
        exp_busy = 0;
        exp_done = 1;
      end
    end else if (exp_done) begin
      exp_done = 0;
    end else if (Clear) begin
      exp_busy = 1;
      clr_idx  = 0;
    end
    if (commit) ref_mem[WriteAddr] = WriteData;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset_N = 1;
    #2 Reset_N = 0;
    #1;
    model_reset();
    n_cmp++; if (OutA !== 8'h00) begin n_err++; $display("FAIL reset_outa: got %h want 00", OutA); end
    n_cmp++; if (OutB !== 8'h00) begin n_err++; $display("FAIL reset_outb: got %h want 00", OutB); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++; if (ClearDone !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", ClearDone); end
    @(negedge Clk);
    Reset_N = 1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_write_read();
    idle_inputs();
    WriteEn = 1; WriteAddr = 3'd1; WriteData = 8'h42; tick();
    idle_inputs(); ReadEnB = 1; ReadAddrB = 3'd1; tick();
    n_cmp++; if (OutB !== 8'h42) begin n_err++; $display("FAIL wr_rd_b_setup: got %h want 42", OutB); end
    idle_inputs(); WriteEn = 1; WriteAddr = 3'd3; WriteData = 8'hA5; tick();
    idle_inputs(); ReadEnA = 1; ReadAddrA = 3'd3; ReadAddrB = 3'd3; tick();
    n_cmp++; if (OutA !== 8'hA5) begin n_err++; $display("FAIL wr_rd_a: got %h want a5", OutA); end
    n_cmp++; if (OutB !== 8'h42) begin n_err++; $display("FAIL wr_rd_b_hold: got %h want 42", OutB); end
    idle_inputs();
  endtask

  task automatic test_bypass();
    idle_inputs();
    WriteEn = 1; WriteAddr = 3'd5; WriteData = 8'h3C;
    ReadEnA = 1; ReadEnB = 1; ReadAddrA = 3'd5; ReadAddrB = 3'd5;
    tick();
    n_cmp++; if (OutA !== 8'h3C) begin n_err++; $display("FAIL bypass_a: got %h want 3c", OutA); end
    n_cmp++; if (OutB !== 8'h3C) begin n_err++; $display("FAIL bypass_b: got %h want 3c", OutB); end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    idle_inputs(); WriteEn = 1; WriteAddr = 3'd0; WriteData = 8'hFF; tick();
    idle_inputs(); ReadEnA = 1; ReadAddrA = 3'd0; tick();
    n_cmp++; if (OutA !== 8'h00) begin n_err++; $display("FAIL zero_reg_read: got %h want 00", OutA); end
    // Same-cycle write and read of entry 0 must not bypass
    idle_inputs(); WriteEn = 1; WriteAddr = 3'd0; WriteData = 8'hFF;
    ReadEnB = 1; ReadAddrB = 3'd0; tick();
    n_cmp++; if (OutB !== 8'h00) begin n_err++; $display("FAIL zero_reg_bypass: got %h want 00", OutB); end
    idle_inputs();
  endtask

  task automatic test_hold();
    idle_inputs(); WriteEn = 1; WriteAddr = 3'd6; WriteData = 8'h66; tick();
    idle_inputs(); ReadEnA = 1; ReadAddrA = 3'd6; tick();
    n_cmp++; if (OutA !== 8'h66) begin n_err++; $display("FAIL hold_setup: got %h want 66", OutA); end
    idle_inputs(); ReadAddrA = 3'd6; WriteEn = 1; WriteAddr = 3'd6; WriteData = 8'h99; tick();
    n_cmp++; if (OutA !== 8'h66) begin n_err++; $display("FAIL hold_during_write: got %h want 66", OutA); end
    WriteEn = 0; tick();
    n_cmp++; if (OutA !== 8'h66) begin n_err++; $display("FAIL hold_after_write: got %h want 66", OutA); end
    ReadEnA = 1; tick();
    n_cmp++; if (OutA !== 8'h99) begin n_err++; $display("FAIL hold_reread: got %h want 99", OutA); end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    for (int a = 1; a < int'(DEPTH); a++) begin
      idle_inputs(); WriteEn = 1; WriteAddr = AW'(a); WriteData = WIDTH'($urandom_range(1, 255)); tick();
    end
    idle_inputs(); Clear = 1; tick();
    Clear = 0;
    for (int c = 0; c < 12; c++) begin
      if (Busy === 1'b1) busy_cnt++;
      if (ClearDone === 1'b1) done_cnt++;
      WriteEn = Busy; WriteAddr = 3'd3; WriteData = 8'h77;
      tick();
    end
    idle_inputs();
    n_cmp++; if (busy_cnt != 8) begin n_err++; $display("FAIL clear_busy_cycles: got %0d want 8", busy_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL clear_done_cycles: got %0d want 1", done_cnt); end
    for (int a = 0; a < int'(DEPTH); a++) begin
      ReadEnA = 1; ReadEnB = 1; ReadAddrA = AW'(a); ReadAddrB = AW'(int'(DEPTH) - 1 - a); tick();
      n_cmp++; if (OutA !== 8'h00) begin n_err++; $display("FAIL clear_entry_a%0d: got %h want 00", a, OutA); end
      n_cmp++; if (OutB !== 8'h00) begin n_err++; $display("FAIL clear_entry_b%0d: got %h want 00", a, OutB); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_during_clear();
    int done_seen = 0;
    idle_inputs(); WriteEn = 1; WriteAddr = 3'd4; WriteData = 8'h11; tick();
    idle_inputs(); ReadEnA = 1; ReadEnB = 1; ReadAddrA = 3'd4; ReadAddrB = 3'd4; tick();
    n_cmp++; if (OutA !== 8'h11 || OutB !== 8'h11) begin
      n_err++; $display("FAIL rst_clr_setup: got %h/%h want 11/11", OutA, OutB);
    end
    idle_inputs(); Clear = 1; tick();
    Clear = 0; tick(); tick(); tick();
    #2 Reset_N = 0;
    #1;
    model_reset();
    n_cmp++; if (OutA !== 8'h00) begin n_err++; $display("FAIL rst_clr_outa: got %h want 00", OutA); end
    n_cmp++; if (OutB !== 8'h00) begin n_err++; $display("FAIL rst_clr_outb: got %h want 00", OutB); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rst_clr_busy: got %b want 0", Busy); end
    n_cmp++; if (ClearDone !== 1'b0) begin n_err++; $display("FAIL rst_clr_done: got %b want 0", ClearDone); end
    @(posedge Clk); @(negedge Clk);
    Reset_N = 1;
    @(posedge Clk); #1;
    for (int c = 0; c < 12; c++) begin
      if (ClearDone !== 1'b0 || Busy !== 1'b0) done_seen++;
      tick();
    end
    n_cmp++; if (done_seen != 0) begin n_err++; $display("FAIL rst_clr_no_pulse: got %0d active cycles want 0", done_seen); end
    WriteEn = 1; WriteAddr = 3'd2; WriteData = 8'h5A; tick();
    idle_inputs(); ReadEnA = 1; ReadAddrA = 3'd2; tick();
    n_cmp++; if (OutA !== 8'h5A) begin n_err++; $display("FAIL rst_clr_resume: got %h want 5a", OutA); end
    idle_inputs();
  endtask

  task automatic test_clear_held();
    idle_inputs(); Clear = 1;
    for (int c = 0; c < 24; c++) begin
      tick();
      n_cmp++; if (Busy !== exp_busy || ClearDone !== exp_done) begin
        n_err++; $display("FAIL clear_held_c%0d: got busy=%b done=%b want busy=%b done=%b",
                          c, Busy, ClearDone, exp_busy, exp_done);
      end
    end
    idle_inputs();
    while (exp_busy || exp_done) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      WriteEn   = 1'($urandom_range(0, 1));
      WriteAddr = AW'($urandom);
      WriteData = WIDTH'($urandom);
      ReadEnA   = 1'($urandom_range(0, 3) != 0);
      ReadEnB   = 1'($urandom_range(0, 3) != 0);
      ReadAddrA = ($urandom_range(0, 3) == 0) ? WriteAddr : AW'($urandom);
      ReadAddrB = ($urandom_range(0, 3) == 0) ? ReadAddrA : AW'($urandom);
      Clear     = 1'($urandom_range(0, 40) == 0);
      tick();
      n_cmp++; if (OutA !== exp_a || OutB !== exp_b || Busy !== exp_busy || ClearDone !== exp_done) begin
        n_err++; $display("FAIL random_c%0d: got A=%h B=%h busy=%b done=%b want A=%h B=%h busy=%b done=%b",
                          c, OutA, OutB, Busy, ClearDone, exp_a, exp_b, exp_busy, exp_done);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_hold();
    test_clear();
    test_reset_during_clear();
    test_clear_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
